capp_cmd_engine: RTL and testbench

- Parametrised byte-stream command engine between the USB UART pipeline and capp_module. Generalises the single-character CAPP control protocol to any word width and cell count.
- Decodes one-byte commands, assembles multi-byte operands and drives the CAPP control lines with programmable pulse widths. Streams back comparand, mask, read lines, tags and tag population count.
- Adds acknowledge bytes, an error byte for unknown commands, and a timeout on the set-high wait.

---
 rtl/capp_cmd_engine.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_capp_cmd_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capp_cmd_engine.sv
// capp_cmd_engine: byte-stream command decoder driving the CAPP control lines.
// Operands and replies travel least significant byte first.
module capp_cmd_engine #(
  parameter int         NUM_BYTES     = 4,
  parameter int         NUM_CELLS     = 16,
  parameter int         SEARCH_CYCLES = 10,
  parameter int         SELECT_CYCLES = 5,
  parameter int         SET_TIMEOUT   = 1024,
  parameter bit         ACK_EN        = 1'b1,
  parameter logic [7:0] ACK_BYTE      = 8'h2E,
  parameter logic [7:0] ERR_BYTE      = 8'h3F
) (
  input  logic                    clk_48mhz,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [8*NUM_BYTES-1:0]  comparand,
  output logic [8*NUM_BYTES-1:0]  mask,
  output logic                    perform_search,
  output logic                    set,
  output logic                    select_first,
  output logic [16*NUM_BYTES-1:0] write_lines,
  input  logic [NUM_CELLS-1:0]    tag_wires,
  input  logic [8*NUM_BYTES-1:0]  read_lines,
  output logic                    busy
);
  localparam int NUM_BITS  = 8*NUM_BYTES;
  localparam int TAG_BYTES = (NUM_CELLS+7)/8;
  localparam int TXW0 = (NUM_BITS > 8*TAG_BYTES) ? NUM_BITS : 8*TAG_BYTES;
  localparam int TXW  = (TXW0 > 16) ? TXW0 : 16;
  localparam int PMAX = (SEARCH_CYCLES > SELECT_CYCLES) ? SEARCH_CYCLES
                                                        : SELECT_CYCLES;
  localparam int PW = $clog2(PMAX+1);
  localparam int TW = $clog2(SET_TIMEOUT+1);
  localparam int BW = $clog2(NUM_BYTES+1);
  localparam int LW = $clog2(TXW/8+1);

  localparam logic [7:0] C_A = 8'h61;
  localparam logic [7:0] C_B = 8'h62;
  localparam logic [7:0] C_C = 8'h63;
  localparam logic [7:0] C_D = 8'h64;
  localparam logic [7:0] C_E = 8'h65;
  localparam logic [7:0] C_F = 8'h66;
  localparam logic [7:0] C_G = 8'h67;
  localparam logic [7:0] C_H = 8'h68;
  localparam logic [7:0] C_I = 8'h69;
  localparam logic [7:0] C_J = 8'h6A;
  localparam logic [7:0] C_K = 8'h6B;
  localparam logic [7:0] C_L = 8'h6C;

  typedef enum logic [2:0] {
    S_CMD, S_RX_WORD, S_EXEC, S_PULSE, S_HOLD, S_WAIT_TAGS, S_TX
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [NUM_BITS-1:0]   word_q, word_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [NUM_BITS-1:0]   comparand_q, comparand_d;
  logic [NUM_BITS-1:0]   mask_q, mask_d;
  logic [2*NUM_BITS-1:0] wl_q, wl_d;
  logic                  set_q, set_d;
  logic                  search_q, search_d;
  logic                  sel_q, sel_d;
  logic                  psrch_q, psrch_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [TXW-1:0]        tx_shift_q, tx_shift_d;
  logic [LW-1:0]         tx_left_q, tx_left_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;

  logic                  go_ack, go_err, go_tx;
  logic [TXW-1:0]        tx_val;
  logic [LW-1:0]         tx_n;
  logic [15:0]           pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CELLS; i++) pop = pop + 16'(tag_wires[i]);
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    comparand_d = comparand_q;
    mask_d      = mask_q;
    wl_d        = wl_q;
    set_d       = set_q;
    search_d    = search_q;
    sel_d       = sel_q;
    psrch_d     = psrch_q;
    pcnt_d      = pcnt_q;
    tcnt_d      = tcnt_q;
    tx_shift_d  = tx_shift_q;
    tx_left_d   = tx_left_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    go_ack      = 1'b0;
    go_err      = 1'b0;
    go_tx       = 1'b0;
    tx_val      = '0;
    tx_n        = '0;
    unique case (state_q)
      S_CMD: if (rx_valid) begin
        cmd_d   = rx_data;
        bcnt_d  = '0;
        state_d = (rx_data == C_A || rx_data == C_C) ? S_RX_WORD : S_EXEC;
      end
      S_RX_WORD: if (rx_valid) begin
        for (int k = 0; k < NUM_BYTES; k++)
          if (bcnt_q == BW'(k)) word_d[8*k +: 8] = rx_data;
        if (bcnt_q == BW'(NUM_BYTES-1)) state_d = S_EXEC;
        else bcnt_d = bcnt_q + 1'b1;
      end
      S_EXEC: unique case (1'b1)
        (cmd_q == C_A): begin
          comparand_d = word_q;
          go_ack      = 1'b1;
        end
        (cmd_q == C_B): begin
          tx_val[NUM_BITS-1:0] = comparand_q;
          tx_n  = LW'(NUM_BYTES);
          go_tx = 1'b1;
        end
        (cmd_q == C_C): begin
          mask_d = word_q;
          go_ack = 1'b1;
        end
        (cmd_q == C_D): begin
          tx_val[NUM_BITS-1:0] = mask_q;
          tx_n  = LW'(NUM_BYTES);
          go_tx = 1'b1;
        end
        (cmd_q == C_E): begin
          sel_d   = 1'b1;
          psrch_d = 1'b0;
          pcnt_d  = PW'(SELECT_CYCLES-1);
          state_d = S_PULSE;
        end
        (cmd_q == C_F): begin
          tx_val[NUM_CELLS-1:0] = tag_wires;
          tx_n  = LW'(TAG_BYTES);
          go_tx = 1'b1;
        end
        (cmd_q == C_G): begin
          set_d   = 1'b1;
          tcnt_d  = '0;
          state_d = S_WAIT_TAGS;
        end
        (cmd_q == C_H): begin
          set_d  = 1'b0;
          go_ack = 1'b1;
        end
        (cmd_q == C_I): begin
          for (int b = 0; b < NUM_BITS; b++) begin
            wl_d[2*b]   = comparand_q[b] & mask_q[b];
            wl_d[2*b+1] = ~comparand_q[b] & mask_q[b];
          end
          go_ack = 1'b1;
        end
        (cmd_q == C_J): begin
          tx_val[NUM_BITS-1:0] = read_lines;
          tx_n  = LW'(NUM_BYTES);
          go_tx = 1'b1;
        end
        (cmd_q == C_K): begin
          search_d = 1'b1;
          psrch_d  = 1'b1;
          pcnt_d   = PW'(SEARCH_CYCLES-1);
          state_d  = S_PULSE;
        end
        (cmd_q == C_L): begin
          tx_val[15:0] = pop;
          tx_n  = LW'(2);
          go_tx = 1'b1;
        end
        default: go_err = 1'b1;
      endcase
      S_PULSE: if (pcnt_q == '0) begin
        search_d = 1'b0;
        sel_d    = 1'b0;
        pcnt_d   = psrch_q ? PW'(SEARCH_CYCLES-1) : PW'(SELECT_CYCLES-1);
        state_d  = S_HOLD;
      end else begin
        pcnt_d = pcnt_q - 1'b1;
      end
      S_HOLD: if (pcnt_q == '0) go_ack = 1'b1;
              else pcnt_d = pcnt_q - 1'b1;
      S_WAIT_TAGS: if (&tag_wires) begin
        go_ack = 1'b1;
      end else if (tcnt_q == TW'(SET_TIMEOUT-1)) begin
        set_d  = 1'b0;
        go_err = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
      S_TX: if (tx_ready) begin
        if (tx_left_q == '0) begin
          tx_valid_d = 1'b0;
          state_d    = S_CMD;
        end else begin
          tx_data_d  = tx_shift_q[7:0];
          tx_shift_d = tx_shift_q >> 8;
          tx_left_d  = tx_left_q - 1'b1;
        end
      end
      default: state_d = S_CMD;
    endcase
    if (go_tx) begin
      tx_data_d  = tx_val[7:0];
      tx_shift_d = tx_val >> 8;
      tx_left_d  = tx_n - 1'b1;
      tx_valid_d = 1'b1;
      state_d    = S_TX;
    end
    if (go_err) begin
      tx_data_d  = ERR_BYTE;
      tx_left_d  = '0;
      tx_valid_d = 1'b1;
      state_d    = S_TX;
    end
    if (go_ack) begin
      if (ACK_EN) begin
        tx_data_d  = ACK_BYTE;
        tx_left_d  = '0;
        tx_valid_d = 1'b1;
        state_d    = S_TX;
      end else begin
        state_d = S_CMD;
      end
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q     <= S_CMD;
      cmd_q       <= '0;
      word_q      <= '0;
      bcnt_q      <= '0;
      comparand_q <= '0;
      mask_q      <= '0;
      wl_q        <= '0;
      set_q       <= 1'b0;
      search_q    <= 1'b0;
      sel_q       <= 1'b0;
      psrch_q     <= 1'b0;
      pcnt_q      <= '0;
      tcnt_q      <= '0;
      tx_shift_q  <= '0;
      tx_left_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      comparand_q <= comparand_d;
      mask_q      <= mask_d;
      wl_q        <= wl_d;
      set_q       <= set_d;
      search_q    <= search_d;
      sel_q       <= sel_d;
      psrch_q     <= psrch_d;
      pcnt_q      <= pcnt_d;
      tcnt_q      <= tcnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_left_q   <= tx_left_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  // rx_ready is forced low while reset is held, even though state is CMD
  assign rx_ready = ~reset & (state_q == S_CMD || state_q == S_RX_WORD);
  assign busy           = (state_q != S_CMD);
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign comparand      = comparand_q;
  assign mask           = mask_q;
  assign write_lines    = wl_q;
  assign set            = set_q;
  assign perform_search = search_q;
  assign select_first   = sel_q;
endmodule

// File: tb/tb_capp_cmd_engine.sv
// tb_capp_cmd_engine: directed stimulus against a command-level reference model.
// A second instance covers the 8-byte / 20-cell configuration.
module tb_capp_cmd_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [31:0] comparand, mask, read_lines;
  logic        perform_search, set, select_first, busy;
  logic [63:0] write_lines;
  logic [15:0] tag_wires;

  capp_cmd_engine dut (
    .clk_48mhz(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .comparand(comparand), .mask(mask),
    .perform_search(perform_search), .set(set),
    .select_first(select_first), .write_lines(write_lines),
    .tag_wires(tag_wires), .read_lines(read_lines), .busy(busy)
  );

  logic [7:0]   rx_data2, tx_data2;
  logic         rx_valid2, rx_ready2, tx_valid2, tx_ready2;
  logic [63:0]  cmp2, mask2, rl2;
  logic         ps2, set2, sf2, busy2;
  logic [127:0] wl2;
  logic [19:0]  tag2;

  capp_cmd_engine #(.NUM_BYTES(8), .NUM_CELLS(20)) dut2 (
    .clk_48mhz(clk), .reset(reset),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .comparand(cmp2), .mask(mask2),
    .perform_search(ps2), .set(set2),
    .select_first(sf2), .write_lines(wl2),
    .tag_wires(tag2), .read_lines(rl2), .busy(busy2)
  );

  localparam logic [7:0] ACK = 8'h2E;
  localparam logic [7:0] ERR = 8'h3F;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_cmp  = '0;
  logic [31:0] m_mask = '0;
  logic [63:0] m_wl   = '0;
  logic        m_set  = 1'b0;
  logic [7:0]  expq[$];
  logic [7:0]  got_log[$];
  logic [7:0]  log2[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) expq.push_back(w[8*k +: 8]);
  endtask

  // Command-level reference: register effects plus the expected reply bytes
  task automatic model_cmd(input logic [7:0] c, input logic [31:0] w);
    logic [15:0] pc;
    case (c)
      "a": begin m_cmp = w; expq.push_back(ACK); end
      "b": push_word(m_cmp);
      "c": begin m_mask = w; expq.push_back(ACK); end
      "d": push_word(m_mask);
      "e", "k": expq.push_back(ACK);
      "f": begin
        expq.push_back(tag_wires[7:0]);
        expq.push_back(tag_wires[15:8]);
      end
      "g": if (tag_wires == 16'hFFFF) begin
        m_set = 1'b1; expq.push_back(ACK);
      end else begin
        m_set = 1'b0; expq.push_back(ERR);
      end
      "h": begin m_set = 1'b0; expq.push_back(ACK); end
      "i": begin
        for (int b = 0; b < 32; b++)
          if (!m_mask[b]) m_wl[2*b +: 2] = 2'b00;
          else if (m_cmp[b]) m_wl[2*b +: 2] = 2'b01;
          else m_wl[2*b +: 2] = 2'b10;
        expq.push_back(ACK);
      end
      "j": push_word(read_lines);
      "l": begin
        pc = 16'($countones(tag_wires));
        expq.push_back(pc[7:0]);
        expq.push_back(pc[15:8]);
      end
      default: expq.push_back(ERR);
    endcase
  endtask

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (pv && !pr) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, pd);
      end
      if (tx_valid && tx_ready) begin
        got_log.push_back(tx_data);
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: got %0h required no byte", tx_data);
        end else if (tx_data !== expq[0]) begin
          errors++;
          $display("FAIL tx_byte: got %0h required %0h", tx_data, expq[0]);
          void'(expq.pop_front());
        end else begin
          void'(expq.pop_front());
        end
      end
      if (!busy) begin
        chk("idle_comparand", comparand, m_cmp);
        chk("idle_mask", mask, m_mask);
        chk("idle_write_lines", write_lines, m_wl);
        chk("idle_set", set, m_set);
        chk("idle_search", perform_search, 0);
        chk("idle_select", select_first, 0);
        chk("idle_rx_ready", rx_ready, 1);
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end else begin
      pv = 1'b0;
    end
  end

  always @(negedge clk)
    if (!reset && tx_valid2 && tx_ready2) log2.push_back(tx_data2);

  task automatic send(input logic [7:0] b);
    int n;
    rx_data = b; rx_valid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!rx_ready && n < 5000);
    chk("rx_accept_bound", rx_ready, 1);
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    int n;
    rx_data2 = b; rx_valid2 = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!rx_ready2 && n < 5000);
    chk("rx2_accept_bound", rx_ready2, 1);
    @(posedge clk); #1 rx_valid2 = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c, input logic [31:0] w);
    send(c);
    if (c == "a" || c == "c")
      for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
    model_cmd(c, w);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy || tx_valid) && n < lim) begin @(posedge clk); #1; n++; end
    chk("idle_bound", {busy, tx_valid}, 0);
    chk("exp_drained", expq.size(), 0);
  endtask

  task automatic wait_idle2(input int lim);
    int n = 0;
    while ((busy2 || tx_valid2) && n < lim) begin @(posedge clk); #1; n++; end
    chk("idle2_bound", {busy2, tx_valid2}, 0);
  endtask

  task automatic pulse_width(input int sel, output int hi, output int lo);
    int n = 0;
    hi = 0; lo = 0;
    while (!tx_valid && n < 3000) begin
      @(negedge clk); n++;
      if ((sel == 0) ? perform_search : ((sel == 1) ? select_first : set)) hi++;
      else if (hi > 0 && !tx_valid) lo++;
    end
  endtask

  int hi, lo;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    tag_wires = '0; read_lines = '0;
    rx_valid2 = 1'b0; rx_data2 = '0; tx_ready2 = 1'b1;
    tag2 = '0; rl2 = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_comparand", comparand, 0);
    chk("rst_write_lines", write_lines, 0);
    chk("rst_strobes", {perform_search, select_first, set}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    send("a"); send(8'h11); send(8'h22);
    chk("mid_word_busy", busy, 1);
    reset = 1'b1; #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_comparand", comparand, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    got_log.delete();
    cmd("b", 0); wait_idle(100);
    chk("b_after_rst_len", got_log.size(), 4);
    chk("b_after_rst_word", {got_log[3], got_log[2], got_log[1], got_log[0]}, 0);
    chk("cmp_after_rst", comparand, 0);

    got_log.delete();
    cmd("a", 32'h12345678); wait_idle(100);
    chk("a_cmp_literal", comparand, 64'h12345678);
    chk("a_ack", got_log[0], ACK);

    got_log.delete();
    tx_ready = 1'b0;
    cmd("b", 0);
    repeat (4) begin @(posedge clk); #1; end
    chk("b_stall_valid", tx_valid, 1);
    tx_ready = 1'b1; @(posedge clk); #1;
    tx_ready = 1'b0; repeat (2) begin @(posedge clk); #1; end
    tx_ready = 1'b1;
    wait_idle(100);
    chk("b_len", got_log.size(), 4);
    chk("b_b0", got_log[0], 8'h78);
    chk("b_b3", got_log[3], 8'h12);

    cmd("a", 32'hFF00FF00); wait_idle(100);
    cmd("c", 32'h0000FFFF); wait_idle(100);
    got_log.delete();
    cmd("i", 0); wait_idle(100);
    chk("i_lines_literal", write_lines, 64'h0000_0000_5555_AAAA);
    chk("i_ack", got_log[0], ACK);
    cmd("d", 0); wait_idle(100);

    cmd("k", 0); pulse_width(0, hi, lo); wait_idle(100);
    chk("search_high", hi, 10);
    chk("search_low", lo, 10);
    cmd("e", 0); pulse_width(1, hi, lo); wait_idle(100);
    chk("select_high", hi, 5);
    chk("select_low", lo, 5);

    tag_wires = 16'h0F01; read_lines = 32'hCAFEF00D;
    got_log.delete();
    cmd("f", 0); wait_idle(100);
    chk("f_tags", {got_log[1], got_log[0]}, 16'h0F01);
    got_log.delete();
    cmd("l", 0); wait_idle(100);
    chk("l_popcount", {got_log[1], got_log[0]}, 16'h0005);
    cmd("j", 0); wait_idle(100);

    got_log.delete();
    tag_wires = 16'h0000;
    cmd("g", 0); pulse_width(2, hi, lo); wait_idle(100);
    chk("set_timeout_high", hi, 1024);
    chk("set_timeout_err", got_log[0], ERR);

    tag_wires = 16'hFFFF;
    cmd("g", 0); wait_idle(20);
    chk("set_held", set, 1);
    cmd("h", 0); wait_idle(20);

    got_log.delete();
    cmd("z", 0); wait_idle(20);
    chk("z_len", got_log.size(), 1);
    chk("z_err", got_log[0], ERR);
    cmd(8'h00, 0); wait_idle(20);

    send2("a");
    for (int k = 0; k < 8; k++) send2(8'(8'h11 * (k + 1)));
    wait_idle2(100);
    chk("w8_cmp", cmp2, 64'h8877665544332211);
    log2.delete();
    send2("b"); wait_idle2(100);
    chk("w8_b_len", log2.size(), 8);
    for (int k = 0; k < 8; k++) chk("w8_b_byte", log2[k], 8'(8'h11 * (k + 1)));
    tag2 = 20'hABCDE;
    log2.delete();
    send2("f"); wait_idle2(100);
    chk("c20_f_len", log2.size(), 3);
    chk("c20_f_tags", {log2[2], log2[1], log2[0]}, 24'h0ABCDE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish by 2ms");
    $fatal(1);
  end
endmodule
